// File: rtl/csa_frame_accum.sv
// csa_frame_accum: sums FRAME_LEN carry-save beats (sum + 2*carry) into a
// saturating accumulator and hands one binary total per frame downstream
// over a valid/ready handshake.
// Optional feature macro: CSA_ACCUM_FLUSH_EN adds the in_flush port, which
// closes a frame early on an accepted beat.
module csa_frame_accum #(
  parameter int IN_W      = 1,
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [IN_W-1:0]  in_carry,
`ifdef CSA_ACCUM_FLUSH_EN
  input  logic             in_flush,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Wide enough that acc + sum + 2*carry can never wrap before the clamp test.
  localparam int SUM_W = ACC_W + IN_W + 2;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_total_q, out_total_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             flush_req;
  logic [SUM_W-1:0] beat_sum;
  logic             sat;
  logic [ACC_W-1:0] acc_sat;
  logic             accept;
  logic             last_beat;

`ifdef CSA_ACCUM_FLUSH_EN
  assign flush_req = in_flush;
`else
  assign flush_req = 1'b0;
`endif

  // Carry-propagate add of the beat into the accumulator, then clamp on overflow.
  always_comb begin
    beat_sum = {{(IN_W + 2){1'b0}}, acc_q}
             + {{(ACC_W + 2){1'b0}}, in_sum}
             + {{(ACC_W + 1){1'b0}}, in_carry, 1'b0};
    sat      = |beat_sum[SUM_W-1:ACC_W];
    acc_sat  = sat ? {ACC_W{1'b1}} : beat_sum[ACC_W-1:0];
  end

  // Next-state logic: accumulate in ACCUM, park the result in HOLD until taken.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_total_d = out_total_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    accept      = in_valid && (state_q == ACCUM);
    last_beat   = (cnt_q == CNT_W'(FRAME_LEN - 1)) || flush_req;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_sat;
          ovf_d = ovf_q | sat;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            out_total_d = acc_sat;
            out_count_d = cnt_q + CNT_W'(1);
            out_ovf_d   = ovf_q | sat;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and result registers; reset discards any partial or pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_total_q <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_total_q <= out_total_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_total = out_total_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_frame_accum.sv
// Testbench for csa_frame_accum (IN_W=1, FRAME_LEN=4, ACC_W=3).
// The reference model just keeps the running true sum and beat count of the
// current frame; the expected total is min(sum, 2**ACC_W-1).
module tb_csa_frame_accum;

  localparam int IN_W      = 1;
  localparam int FRAME_LEN = 4;
  localparam int ACC_W     = 3;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int MAXV      = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum = '0;
  logic [IN_W-1:0]  in_carry = '0;
  logic             in_flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int vectors = 0;
  int miscompares = 0;
  int modelSum = 0;
  int modelCnt = 0;
  bit frameClosed = 1'b0;
  int lastTotal = 0;

  csa_frame_accum #(
    .IN_W(IN_W), .FRAME_LEN(FRAME_LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sum(in_sum),
    .in_carry(in_carry),
`ifdef CSA_ACCUM_FLUSH_EN
    .in_flush(in_flush),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_total(out_total),
    .out_count(out_count),
    .out_ovf(out_ovf)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int s, input int c, input bit f);
    in_valid = v;
    in_sum   = IN_W'(s);
    in_carry = IN_W'(c);
    in_flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; also advances the model's view of the frame.
  task automatic driveBeat(input int s, input int c, input bit f);
    checkOutput("in_ready_before_beat", in_ready, 1);
    applyStimulus(1'b1, s, c, f);
    tick();
    applyStimulus(1'b0, 0, 0, 1'b0);
    modelSum += s + 2 * c;
    modelCnt++;
`ifdef CSA_ACCUM_FLUSH_EN
    frameClosed = f || (modelCnt == FRAME_LEN);
`else
    frameClosed = (modelCnt == FRAME_LEN);
`endif
  endtask

  // A cycle with in_valid low and junk on the data lines must change nothing.
  task automatic idleCycle();
    applyStimulus(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    tick();
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("idle_out_valid", out_valid, 0);
  endtask

  task automatic checkResult(input string tag);
    int expTotal;
    expTotal = (modelSum > MAXV) ? MAXV : modelSum;
    checkOutput({tag, "_out_valid"}, out_valid, 1);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_out_total"}, out_total, expTotal);
    checkOutput({tag, "_out_count"}, out_count, modelCnt);
    checkOutput({tag, "_out_ovf"}, out_ovf, (modelSum > MAXV) ? 1 : 0);
    lastTotal = expTotal;
    modelSum = 0;
    modelCnt = 0;
    frameClosed = 1'b0;
  endtask

  task automatic takeResult(input int stall);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_out_total", out_total, lastTotal);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("take_out_valid", out_valid, 0);
    checkOutput("take_in_ready", in_ready, 1);
    checkOutput("take_total_kept", out_total, lastTotal);
  endtask

  // Directed steps first, then randomized frames against the model.
  initial begin
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_total", out_total, 0);
    checkOutput("rst_out_count", out_count, 0);
    checkOutput("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;

    driveBeat(1, 0, 1'b0);
    driveBeat(0, 1, 1'b0);
    driveBeat(1, 1, 1'b0);
    driveBeat(0, 0, 1'b0);
    checkOutput("frame_total_is_6", out_total, 6);
    checkResult("frame");
    takeResult(5);

    for (int i = 0; i < FRAME_LEN; i++) driveBeat(1, 1, 1'b0);
    checkOutput("sat_total_is_7", out_total, 7);
    checkResult("sat");
    takeResult(0);
    for (int i = 0; i < FRAME_LEN; i++) driveBeat(0, 0, 1'b0);
    checkResult("zero");
    takeResult(1);

    driveBeat(1, 1, 1'b0);
    driveBeat(1, 1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelSum = 0;
    modelCnt = 0;
    checkOutput("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < FRAME_LEN; i++) driveBeat(1, 0, 1'b0);
    checkOutput("midrst_total_is_4", out_total, 4);
    checkResult("midrst");
    takeResult(2);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("hold_rst_out_valid", out_valid, 0);
    checkOutput("hold_rst_out_total", out_total, 0);

`ifdef CSA_ACCUM_FLUSH_EN
    driveBeat(1, 1, 1'b0);
    driveBeat(1, 0, 1'b1);
    checkOutput("flush_count_is_2", out_count, 2);
    checkResult("flush");
    takeResult(1);
    applyStimulus(1'b0, 1, 1, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 0, 1'b0);
    checkOutput("flush_novalid_out_valid", out_valid, 0);
    for (int i = 0; i < FRAME_LEN; i++) driveBeat(0, 1, 1'b0);
    checkResult("after_flush");
    takeResult(0);
`endif

    for (int f = 0; f < 12; f++) begin
      int guard;
      guard = 0;
      while (!frameClosed && guard < 4 * FRAME_LEN) begin
        guard++;
        if ($urandom_range(0, 2) == 0) idleCycle();
`ifdef CSA_ACCUM_FLUSH_EN
        driveBeat($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 4) == 0));
`else
        driveBeat($urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
`endif
      end
      checkOutput("rand_frame_closed", frameClosed, 1);
      checkResult("rand");
      takeResult($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
